gps_cfg_ctrl: RTL and testbench

Configuration sequencer for the GPS signal generator core. It receives byte-framed commands from the chip's input pins, validates a full parameter set, and owns the core's run/stop enable. It commits new satellite, code-phase, Doppler, SNR and mode settings atomically. While the core is running, a commit happens only at a C/A code epoch, so the generated signal never changes mid-code-period.

---
 rtl/gps_cfg_ctrl_if.sv | 12 +
 rtl/gps_cfg_ctrl.sv | 247 ++++++++++++++++++++++++
 tb/tb_gps_cfg_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gps_cfg_ctrl_if.sv
// Byte-wide configuration link into gps_cfg_ctrl.
// Handshake: a byte moves on every rising clk_in edge where cfg_valid_in and
// cfg_ready_out are both high. While valid is high and ready is low, the
// master holds cfg_data_in stable. Ready does not depend on valid.
interface gps_cfg_ctrl_if;
  logic       cfg_valid_in;
  logic [7:0] cfg_data_in;
  logic       cfg_ready_out;

  modport master (output cfg_valid_in, output cfg_data_in, input cfg_ready_out);
  modport slave  (input cfg_valid_in, input cfg_data_in, output cfg_ready_out);
endinterface

// File: rtl/gps_cfg_ctrl.sv
// gps_cfg_ctrl: command sequencer for the GPS signal generator core.
// It parses WRITE/RUN/HALT byte frames and owns the core enable. It also
// commits satellite, code phase, Doppler, SNR and mode settings atomically.
// While the core runs, a commit waits for a C/A code epoch (or a timeout), so
// the generated signal never changes in the middle of a code period.
module gps_cfg_ctrl #(
  parameter int CA_LEN       = 16368,
  parameter int BYTE_TIMEOUT = 1024,
  parameter int PEND_TIMEOUT = 32768
) (
  input  logic          clk_in,
  input  logic          rst_in_n,
  gps_cfg_ctrl_if.slave cfg,
  input  logic          epoch_in,
  output logic          ena_out,
  output logic [4:0]    n_sat_out,
  output logic [15:0]   ca_phase_out,
  output logic [7:0]    doppler_out,
  output logic [7:0]    snr_out,
  output logic          use_preset_out,
  output logic [1:0]    preset_sel_out,
  output logic          use_msg_preset_out,
  output logic          noise_off_out,
  output logic          signal_off_out,
  output logic          commit_out,
  output logic          err_out,
  output logic [1:0]    state_dbg_out
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PAYLOAD = 2'd1,
    S_PEND    = 2'd2
  } state_t;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_RUN   = 8'h02;
  localparam logic [7:0] CMD_HALT  = 8'h03;

  // A single timeout counter serves both the byte gap (PAYLOAD) and the epoch
  // wait (PEND); the two states never overlap.
  localparam int TMO_MAX = (PEND_TIMEOUT > BYTE_TIMEOUT) ? PEND_TIMEOUT : BYTE_TIMEOUT;
  localparam int TW      = $clog2(TMO_MAX);
  localparam logic [TW-1:0] BYTE_LAST = TW'(BYTE_TIMEOUT - 1);
  localparam logic [TW-1:0] PEND_LAST = TW'(PEND_TIMEOUT - 1);
  localparam logic [16:0]   CA_LEN_V  = 17'(CA_LEN);

  state_t        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          ready_q, ready_d;
  logic          ena_q, ena_d;
  logic          commit_q, commit_d;
  logic          err_q, err_d;

  // Shadow copy of the frame being received
  logic [7:0] sh_sat_q, sh_sat_d;
  logic [7:0] sh_ph_hi_q, sh_ph_hi_d;
  logic [7:0] sh_ph_lo_q, sh_ph_lo_d;
  logic [7:0] sh_dop_q, sh_dop_d;
  logic [7:0] sh_snr_q, sh_snr_d;
  logic [5:0] sh_flags_q, sh_flags_d;

  // Live settings seen by the core
  logic [4:0]  live_sat_q, live_sat_d;
  logic [15:0] live_phase_q, live_phase_d;
  logic [7:0]  live_dop_q, live_dop_d;
  logic [7:0]  live_snr_q, live_snr_d;
  logic [5:0]  live_flags_q, live_flags_d;

  logic accept;
  logic frame_bad;
  logic do_commit;

  assign accept = cfg.cfg_valid_in & ready_q;

  // Frame check applied when the flags byte (the last one) is on the bus
  assign frame_bad = (sh_sat_q[7:5] != 3'd0) ||
                     ({1'b0, sh_ph_hi_q, sh_ph_lo_q} >= CA_LEN_V) ||
                     (cfg.cfg_data_in[7:6] != 2'd0);

  // Next-state, shadow capture, validation and commit decision
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    tmo_d        = tmo_q;
    ena_d        = ena_q;
    commit_d     = 1'b0;
    err_d        = 1'b0;
    do_commit    = 1'b0;
    sh_sat_d     = sh_sat_q;
    sh_ph_hi_d   = sh_ph_hi_q;
    sh_ph_lo_d   = sh_ph_lo_q;
    sh_dop_d     = sh_dop_q;
    sh_snr_d     = sh_snr_q;
    sh_flags_d   = sh_flags_q;
    live_sat_d   = live_sat_q;
    live_phase_d = live_phase_q;
    live_dop_d   = live_dop_q;
    live_snr_d   = live_snr_q;
    live_flags_d = live_flags_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (cfg.cfg_data_in)
            CMD_WRITE: begin
              state_d = S_PAYLOAD;
              idx_d   = 3'd0;
              tmo_d   = '0;
            end
            CMD_RUN:  ena_d = 1'b1;
            CMD_HALT: ena_d = 1'b0;
            default:  err_d = 1'b1;
          endcase
        end
      end

      S_PAYLOAD: begin
        if (accept) begin
          tmo_d = '0;
          idx_d = 3'(idx_q + 3'd1);
          case (idx_q)
            3'd0: sh_sat_d   = cfg.cfg_data_in;
            3'd1: sh_ph_hi_d = cfg.cfg_data_in;
            3'd2: sh_ph_lo_d = cfg.cfg_data_in;
            3'd3: sh_dop_d   = cfg.cfg_data_in;
            3'd4: sh_snr_d   = cfg.cfg_data_in;
            default: begin
              sh_flags_d = cfg.cfg_data_in[5:0];
              idx_d      = 3'd0;
              if (frame_bad) begin
                err_d   = 1'b1;
                state_d = S_IDLE;
              end else if (ena_q) begin
                state_d = S_PEND;
                tmo_d   = '0;
              end else begin
                do_commit = 1'b1;
                state_d   = S_IDLE;
              end
            end
          endcase
        end else if (tmo_q == BYTE_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
          idx_d   = 3'd0;
        end else begin
          tmo_d = TW'(tmo_q + 1'b1);
        end
      end

      S_PEND: begin
        // An epoch wins; otherwise the commit is forced after the wait limit
        if (epoch_in || (tmo_q == PEND_LAST)) begin
          do_commit = 1'b1;
          state_d   = S_IDLE;
        end else begin
          tmo_d = TW'(tmo_q + 1'b1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    // A rejected or aborted frame leaves nothing behind in the shadow
    if (err_d && (state_q == S_PAYLOAD)) begin
      sh_sat_d   = '0;
      sh_ph_hi_d = '0;
      sh_ph_lo_d = '0;
      sh_dop_d   = '0;
      sh_snr_d   = '0;
      sh_flags_d = '0;
    end

    if (do_commit) begin
      live_sat_d   = sh_sat_d[4:0];
      live_phase_d = {sh_ph_hi_d, sh_ph_lo_d};
      live_dop_d   = sh_dop_d;
      live_snr_d   = sh_snr_d;
      live_flags_d = sh_flags_d;
      commit_d     = 1'b1;
    end
  end

  // Ready is registered from the next state so it is low exactly while in PEND
  assign ready_d = (state_d != S_PEND);

  // State, counters, shadow and live registers with synchronous reset
  always_ff @(posedge clk_in) begin
    if (!rst_in_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      tmo_q        <= '0;
      ready_q      <= 1'b1;
      ena_q        <= 1'b0;
      commit_q     <= 1'b0;
      err_q        <= 1'b0;
      sh_sat_q     <= '0;
      sh_ph_hi_q   <= '0;
      sh_ph_lo_q   <= '0;
      sh_dop_q     <= '0;
      sh_snr_q     <= '0;
      sh_flags_q   <= '0;
      live_sat_q   <= '0;
      live_phase_q <= '0;
      live_dop_q   <= '0;
      live_snr_q   <= '0;
      live_flags_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      tmo_q        <= tmo_d;
      ready_q      <= ready_d;
      ena_q        <= ena_d;
      commit_q     <= commit_d;
      err_q        <= err_d;
      sh_sat_q     <= sh_sat_d;
      sh_ph_hi_q   <= sh_ph_hi_d;
      sh_ph_lo_q   <= sh_ph_lo_d;
      sh_dop_q     <= sh_dop_d;
      sh_snr_q     <= sh_snr_d;
      sh_flags_q   <= sh_flags_d;
      live_sat_q   <= live_sat_d;
      live_phase_q <= live_phase_d;
      live_dop_q   <= live_dop_d;
      live_snr_q   <= live_snr_d;
      live_flags_q <= live_flags_d;
    end
  end

  assign cfg.cfg_ready_out   = ready_q;
  assign ena_out             = ena_q;
  assign n_sat_out           = live_sat_q;
  assign ca_phase_out        = live_phase_q;
  assign doppler_out         = live_dop_q;
  assign snr_out             = live_snr_q;
  assign use_preset_out      = live_flags_q[0];
  assign preset_sel_out      = live_flags_q[2:1];
  assign use_msg_preset_out  = live_flags_q[3];
  assign noise_off_out       = live_flags_q[4];
  assign signal_off_out      = live_flags_q[5];
  assign commit_out          = commit_q;
  assign err_out             = err_q;
  assign state_dbg_out       = state_q;

endmodule

// File: tb/tb_gps_cfg_ctrl.sv
// Testbench for gps_cfg_ctrl: directed frames with hand-computed results.
// The driver pushes each expected commit/err event into exp_q, and a
// negedge monitor pops and compares whenever the DUT pulses an event.
module tb_gps_cfg_ctrl;

  // ---------------- clock / reset ----------------
  logic clk_in = 1'b0;
  logic rst_in_n = 1'b0;
  always #5 clk_in = ~clk_in;

  gps_cfg_ctrl_if cfg_if ();

  logic        epoch_in;
  logic        ena_out;
  logic [4:0]  n_sat_out;
  logic [15:0] ca_phase_out;
  logic [7:0]  doppler_out;
  logic [7:0]  snr_out;
  logic        use_preset_out;
  logic [1:0]  preset_sel_out;
  logic        use_msg_preset_out;
  logic        noise_off_out;
  logic        signal_off_out;
  logic        commit_out;
  logic        err_out;
  logic [1:0]  state_dbg_out;

  gps_cfg_ctrl dut (
    .clk_in             (clk_in),
    .rst_in_n           (rst_in_n),
    .cfg                (cfg_if),
    .epoch_in           (epoch_in),
    .ena_out            (ena_out),
    .n_sat_out          (n_sat_out),
    .ca_phase_out       (ca_phase_out),
    .doppler_out        (doppler_out),
    .snr_out            (snr_out),
    .use_preset_out     (use_preset_out),
    .preset_sel_out     (preset_sel_out),
    .use_msg_preset_out (use_msg_preset_out),
    .noise_off_out      (noise_off_out),
    .signal_off_out     (signal_off_out),
    .commit_out         (commit_out),
    .err_out            (err_out),
    .state_dbg_out      (state_dbg_out)
  );

  // Live settings packed as {sat, phase, doppler, snr, flags[5:0]}
  logic [42:0] live_obs;
  assign live_obs = {n_sat_out, ca_phase_out, doppler_out, snr_out, signal_off_out,
                     noise_off_out, use_msg_preset_out, preset_sel_out, use_preset_out};

  // ---------------- scoreboard ----------------
  localparam int W = 45;  // {commit, err, live[42:0]}
  logic [W-1:0] exp_q[$];
  logic [42:0]  live_m = '0;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [42:0] mk_live(input logic [4:0] s, input logic [15:0] ph,
                                          input logic [7:0] d, input logic [7:0] n,
                                          input logic [5:0] f);
    return {s, ph, d, n, f};
  endfunction

  task automatic push_commit(input logic [42:0] v);
    live_m = v;
    exp_q.push_back({2'b10, v});
  endtask

  task automatic push_err();
    exp_q.push_back({2'b01, live_m});
  endtask

  // Monitor: every commit/err pulse must match the next expected event
  always @(negedge clk_in) begin
    if (rst_in_n && (commit_out || err_out)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got=%0h expected=none", {commit_out, err_out, live_obs});
      end else begin
        chk("event", 64'({commit_out, err_out, live_obs}), 64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    cfg_if.cfg_valid_in = 1'b1;
    cfg_if.cfg_data_in  = b;
    while (!cfg_if.cfg_ready_out && n < 100) begin
      @(negedge clk_in);
      n++;
    end
    if (n >= 100) chk("ready_wait", 64'(n), 64'(0));
    @(negedge clk_in);
    cfg_if.cfg_valid_in = 1'b0;
  endtask

  task automatic send_write(input logic [7:0] s, input logic [7:0] ph, input logic [7:0] pl,
                            input logic [7:0] d, input logic [7:0] n, input logic [7:0] f,
                            input logic ep_last);
    send_byte(8'h01);
    send_byte(s);
    send_byte(ph);
    send_byte(pl);
    send_byte(d);
    send_byte(n);
    epoch_in = ep_last;
    send_byte(f);
    epoch_in = 1'b0;
  endtask

  // Count negedges until the selected pulse appears (bounded)
  task automatic wait_pulse(input bit want_commit, input int limit, output int k);
    k = 0;
    do begin
      @(negedge clk_in);
      k++;
    end while (!(want_commit ? commit_out : err_out) && k < limit);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    int bad;
    logic [42:0] held;

    cfg_if.cfg_valid_in = 1'b0;
    cfg_if.cfg_data_in  = 8'h00;
    epoch_in = 1'b0;

    // Reset values
    repeat (3) @(negedge clk_in);
    chk("rst_live", 64'(live_obs), 64'(0));
    chk("rst_ena", 64'(ena_out), 64'(0));
    chk("rst_pulses", 64'({commit_out, err_out}), 64'(0));
    chk("rst_ready", 64'(cfg_if.cfg_ready_out), 64'(1));
    chk("rst_state", 64'(state_dbg_out), 64'(0));
    rst_in_n = 1'b1;
    @(negedge clk_in);

    // Halted: immediate commit
    push_commit(mk_live(5'h05, 16'h1234, 8'h40, 8'h03, 6'h11));
    send_write(8'h05, 8'h12, 8'h34, 8'h40, 8'h03, 8'h11, 1'b0);
    chk("w1_commit_cycle", 64'(commit_out), 64'(1));
    chk("w1_ena", 64'(ena_out), 64'(0));
    chk("w1_ready", 64'(cfg_if.cfg_ready_out), 64'(1));

    // RUN twice: enable rises once, no error
    send_byte(8'h02);
    chk("run_ena", 64'(ena_out), 64'(1));
    send_byte(8'h02);
    chk("run2_ena", 64'({ena_out, err_out}), 64'(2'b10));

    // Running: frame waits in PEND for an epoch 50 cycles later
    held = live_m;
    push_commit(mk_live(5'h07, 16'h0010, 8'h00, 8'h02, 6'h00));
    send_write(8'h07, 8'h00, 8'h10, 8'h00, 8'h02, 8'h00, 1'b0);
    chk("pend_state", 64'(state_dbg_out), 64'(2));
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (cfg_if.cfg_ready_out !== 1'b0 || live_obs !== held || commit_out !== 1'b0) bad++;
      @(negedge clk_in);
    end
    chk("pend_hold", 64'(bad), 64'(0));
    epoch_in = 1'b1;
    @(negedge clk_in);
    epoch_in = 1'b0;
    chk("epoch_commit", 64'(commit_out), 64'(1));
    chk("epoch_ready_ena", 64'({cfg_if.cfg_ready_out, ena_out}), 64'(2'b11));

    // Epoch together with the last byte does not commit; forced commit follows
    push_commit(mk_live(5'h0A, 16'h3FEF, 8'h80, 8'h07, 6'h2A));
    send_write(8'h0A, 8'h3F, 8'hEF, 8'h80, 8'h07, 8'h2A, 1'b1);
    chk("coinc_epoch_no_commit", 64'({commit_out, cfg_if.cfg_ready_out}), 64'(0));
    wait_pulse(1'b1, 40000, k);
    chk("forced_commit_cycles", 64'(k), 64'(32768));
    chk("forced_ready", 64'(cfg_if.cfg_ready_out), 64'(1));

    // Halt, then rejected frames
    send_byte(8'h03);
    chk("halt_ena", 64'(ena_out), 64'(0));
    push_err();
    send_write(8'h01, 8'h3F, 8'hF0, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("rej_phase", 64'({err_out, state_dbg_out}), 64'(3'b100));
    push_err();
    send_write(8'h25, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("rej_sat", 64'(err_out), 64'(1));
    push_err();
    send_write(8'h05, 8'h00, 8'h10, 8'h00, 8'h00, 8'hC0, 1'b0);
    chk("rej_flags", 64'(err_out), 64'(1));
    // Largest legal sat and flags still commit
    push_commit(mk_live(5'h1F, 16'h0000, 8'hFF, 8'h08, 6'h3F));
    send_write(8'h1F, 8'h00, 8'h00, 8'hFF, 8'h08, 8'h3F, 1'b0);
    chk("max_fields_commit", 64'(commit_out), 64'(1));

    // Byte timeout after 3 payload bytes
    push_err();
    send_byte(8'h01);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    wait_pulse(1'b0, 2000, k);
    chk("byte_tmo_cycles", 64'(k), 64'(1024));
    chk("byte_tmo_state", 64'(state_dbg_out), 64'(0));
    push_commit(mk_live(5'h02, 16'h0100, 8'h55, 8'h04, 6'h09));
    send_write(8'h02, 8'h01, 8'h00, 8'h55, 8'h04, 8'h09, 1'b0);
    chk("after_tmo_commit", 64'(commit_out), 64'(1));

    // Unknown command
    push_err();
    send_byte(8'h7E);
    chk("unknown_cmd", 64'({err_out, ena_out, state_dbg_out}), 64'(4'b1000));

    // Reset in the middle of a frame while running
    send_byte(8'h02);
    send_byte(8'h01);
    send_byte(8'h05);
    send_byte(8'h12);
    chk("mid_frame_state", 64'({ena_out, state_dbg_out}), 64'(3'b101));
    rst_in_n = 1'b0;
    @(negedge clk_in);
    rst_in_n = 1'b1;
    live_m = '0;
    chk("mid_rst_live", 64'(live_obs), 64'(0));
    chk("mid_rst_ctrl", 64'({ena_out, commit_out, err_out, cfg_if.cfg_ready_out, state_dbg_out}),
        64'(6'b000100));

    repeat (5) @(negedge clk_in);
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
